// File: rtl/commit_arbiter_pkg.sv
// Backend package: issue number type and the commit record latched by the arbiter.
package commit_arbiter_pkg;

    localparam int ISSUE_NO_W = 8;
    localparam int MAX_SRC_W  = 3;

    typedef logic [ISSUE_NO_W-1:0] issue_no_t;

    typedef struct packed {
        issue_no_t             Issue_No;
        logic [MAX_SRC_W-1:0]  Src;
    } commit_req_t;

endpackage

// File: rtl/commit_rr_arb.sv
// Pure combinational round-robin pick: scans upward from the pointer, wrapping,
// and returns a one-hot grant (gated by enable) plus the binary winner index.
module commit_rr_arb #(
    parameter int NUM_REQ   = 2,
    parameter int WIDTH_SRC = 1
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [WIDTH_SRC-1:0] ptr_i,
    input  logic                 en_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [WIDTH_SRC-1:0] winner_o
);

    int   idx;
    logic found;

    // Winner search is independent of enable so that enable only gates the final grant
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                winner_o = WIDTH_SRC'(idx);
            end
        end
        if (en_i && found) begin
            grant_o[winner_o] = 1'b1;
        end
    end

endmodule

// File: rtl/commit_arbiter.sv
// Shares the backend commit port between reorder buffers: round-robin grant,
// one-deep registered commit on a valid/ready bus, and a wrapping commit counter.
module commit_arbiter
    import commit_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int WIDTH_CNT = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 I_Req,
    input  issue_no_t [NUM_REQ-1:0]            I_Issue_No,
    output logic [NUM_REQ-1:0]                 O_Grant,
    output logic                               O_Commit_Valid,
    output issue_no_t                          O_Commit_No,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] O_Commit_Src,
    input  logic                               I_Commit_Ready,
    output logic [WIDTH_CNT-1:0]               O_Num_Commit,
    output logic                               O_Busy
);

    localparam int WIDTH_SRC = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [WIDTH_SRC-1:0] ptr_q, ptr_d;
    logic                 valid_q, valid_d;
    commit_req_t          commit_q, commit_d;
    logic [WIDTH_CNT-1:0] cnt_q, cnt_d;

    logic                 free;
    logic                 arbEn;
    logic                 grantAny;
    logic                 handshake;
    logic [WIDTH_SRC-1:0] winner;

    // The output slot can take a new entry when empty or being drained this cycle;
    // reset suppresses any grant so no buffer pops an entry that would be discarded
    assign free      = ~valid_q | I_Commit_Ready;
    assign arbEn     = free & ~reset;
    assign handshake = valid_q & I_Commit_Ready;
    assign grantAny  = |O_Grant;

    commit_rr_arb #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH_SRC (WIDTH_SRC)
    ) u_rr_arb (
        .req_i    (I_Req),
        .ptr_i    (ptr_q),
        .en_i     (arbEn),
        .grant_o  (O_Grant),
        .winner_o (winner)
    );

    // Next-state: a grant reloads the slot (even while it is handed off), a bare handshake empties it
    always_comb begin
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        commit_d = commit_q;
        cnt_d    = cnt_q;
        if (grantAny) begin
            valid_d           = 1'b1;
            commit_d.Issue_No = I_Issue_No[winner];
            commit_d.Src      = MAX_SRC_W'(winner);
            ptr_d             = (int'(winner) == NUM_REQ - 1) ? '0 : winner + WIDTH_SRC'(1);
        end else if (handshake) begin
            valid_d = 1'b0;
        end
        if (handshake) begin
            cnt_d = cnt_q + WIDTH_CNT'(1);
        end
    end

    // State registers; reset drops any held commit
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q    <= '0;
            valid_q  <= 1'b0;
            commit_q <= '0;
            cnt_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            commit_q <= commit_d;
            cnt_q    <= cnt_d;
        end
    end

    assign O_Commit_Valid = valid_q;
    assign O_Commit_No    = commit_q.Issue_No;
    assign O_Commit_Src   = commit_q.Src[WIDTH_SRC-1:0];
    assign O_Num_Commit   = cnt_q;
    assign O_Busy         = valid_q | (|I_Req);

endmodule

// File: tb/tb_commit_arbiter.sv
// Self-checking bench for commit_arbiter (2 requesters, 4-bit counter):
// a reference model predicts grants and a scoreboard holds expected commits.
module tb_commit_arbiter;
    import commit_arbiter_pkg::*;

    logic            clock;
    logic            reset;
    logic [1:0]      I_Req;
    issue_no_t [1:0] I_Issue_No;
    logic [1:0]      O_Grant;
    logic            O_Commit_Valid;
    issue_no_t       O_Commit_No;
    logic            O_Commit_Src;
    logic            I_Commit_Ready;
    logic [3:0]      O_Num_Commit;
    logic            O_Busy;

    int totalCnt = 0;
    int badCnt   = 0;

    // Reference model state
    commit_req_t sb[$];
    logic        mValid;
    int          mPtr;
    logic [3:0]  mCount;

    commit_arbiter #(
        .NUM_REQ   (2),
        .WIDTH_CNT (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .I_Req          (I_Req),
        .I_Issue_No     (I_Issue_No),
        .O_Grant        (O_Grant),
        .O_Commit_Valid (O_Commit_Valid),
        .O_Commit_No    (O_Commit_No),
        .O_Commit_Src   (O_Commit_Src),
        .I_Commit_Ready (I_Commit_Ready),
        .O_Num_Commit   (O_Num_Commit),
        .O_Busy         (O_Busy)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point for every check
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Hold reset for one cycle with the given inputs, then check the cleared state
    task automatic doReset(input logic [1:0] req, input logic ready);
        reset          = 1'b1;
        I_Req          = req;
        I_Issue_No[0]  = 8'h33;
        I_Issue_No[1]  = 8'h44;
        I_Commit_Ready = ready;
        #1;
        checkOutput("rstGrant", 32'(O_Grant), 32'd0);
        @(posedge clock);
        #1;
        sb.delete();
        mValid = 1'b0;
        mPtr   = 0;
        mCount = 4'd0;
        checkOutput("rstValid", 32'(O_Commit_Valid), 32'd0);
        checkOutput("rstNo", 32'(O_Commit_No), 32'd0);
        checkOutput("rstSrc", 32'(O_Commit_Src), 32'd0);
        checkOutput("rstCnt", 32'(O_Num_Commit), 32'd0);
    endtask

    // Drive one cycle, check combinational and registered outputs against the model, advance
    task automatic applyStimulus(input logic [1:0] req, input issue_no_t n0, input issue_no_t n1,
                                 input logic ready);
        logic [1:0]  expGrant;
        int          win;
        logic        free;
        commit_req_t e;
        reset          = 1'b0;
        I_Req          = req;
        I_Issue_No[0]  = n0;
        I_Issue_No[1]  = n1;
        I_Commit_Ready = ready;
        #1;
        free     = !mValid || ready;
        expGrant = 2'b00;
        win      = -1;
        if (free) begin
            for (int off = 0; off < 2; off++) begin
                int idx;
                idx = (mPtr + off) % 2;
                if (win < 0 && req[idx]) win = idx;
            end
        end
        if (win >= 0) expGrant[win] = 1'b1;
        checkOutput("grant", 32'(O_Grant), 32'(expGrant));
        checkOutput("valid", 32'(O_Commit_Valid), 32'(mValid));
        checkOutput("busy", 32'(O_Busy), 32'(mValid | (|req)));
        checkOutput("count", 32'(O_Num_Commit), 32'(mCount));
        if (mValid && sb.size() > 0) begin
            e = sb[0];
            checkOutput("commitNo", 32'(O_Commit_No), 32'(e.Issue_No));
            checkOutput("commitSrc", 32'(O_Commit_Src), 32'(e.Src));
            if (ready) begin
                void'(sb.pop_front());
                mCount = mCount + 4'd1;
            end
        end
        if (win >= 0) begin
            e.Issue_No = (win == 0) ? n0 : n1;
            e.Src      = 3'(win);
            sb.push_back(e);
            mValid = 1'b1;
            mPtr   = (win + 1) % 2;
        end else if (mValid && ready) begin
            mValid = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int guard;
        reset          = 1'b1;
        I_Req          = 2'b00;
        I_Issue_No     = '0;
        I_Commit_Ready = 1'b0;
        mValid         = 1'b0;
        mPtr           = 0;
        mCount         = 4'd0;

        // Reset with idle inputs, then a single commit from buffer 0
        doReset(2'b00, 1'b0);
        applyStimulus(2'b01, 8'd5, 8'd0, 1'b1);
        checkOutput("firstNo", 32'(O_Commit_No), 32'd5);
        applyStimulus(2'b00, 8'd0, 8'd0, 1'b1);
        checkOutput("firstCnt", 32'(O_Num_Commit), 32'd1);

        // Both buffers requesting with ready high: alternating back-to-back commits
        doReset(2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 8'(8'h10 + i), 8'(8'h20 + i), 1'b1);
        end
        applyStimulus(2'b00, 8'd0, 8'd0, 1'b1);
        checkOutput("rrCnt", 32'(O_Num_Commit), 32'd4);

        // Stall: valid held with ready low, buffer 1 waiting
        applyStimulus(2'b01, 8'h51, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b10, 8'h00, 8'h62, 1'b0);
        end
        applyStimulus(2'b10, 8'h00, 8'h62, 1'b1);
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);

        // Buffer 1 pulses once during a stall and withdraws
        applyStimulus(2'b01, 8'h71, 8'h00, 1'b0);
        applyStimulus(2'b10, 8'h00, 8'h7f, 1'b0);
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b0);
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);

        // Reach a count of 7, stall a held commit, then reset mid-operation
        doReset(2'b00, 1'b0);
        guard = 0;
        while (mCount != 4'd7 && guard < 40) begin
            applyStimulus(2'b01, 8'(guard), 8'h00, 1'b1);
            guard++;
        end
        applyStimulus(2'b01, 8'h99, 8'h00, 1'b0);
        applyStimulus(2'b11, 8'h98, 8'h97, 1'b0);
        checkOutput("preRstCnt", 32'(O_Num_Commit), 32'd7);
        doReset(2'b11, 1'b0);
        applyStimulus(2'b11, 8'h01, 8'h02, 1'b1);
        checkOutput("postRstSrc", 32'(O_Commit_Src), 32'd0);
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);

        // 17 handshakes wrap the 4-bit counter to 1
        doReset(2'b00, 1'b0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(2'b01, 8'(8'h80 + i), 8'h00, 1'b1);
        end
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b1);
        checkOutput("wrapCnt", 32'(O_Num_Commit), 32'd1);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
